crc_checker: RTL and testbench

Receive-side companion to the CRC-4 generator. It accepts one 12-bit codeword {data[7:0], crc[3:0]} per transaction and recomputes the polynomial remainder serially, one bit per cycle, MSB first. It then presents the recovered data byte, the 4-bit syndrome and a pass/fail flag to the consumer. It also keeps saturating frame and error counters for link monitoring.

---
 rtl/crc_checker.sv | 130 +++++++++++++
 tb/tb_crc_checker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/crc_checker.sv
// rtl/crc_checker.sv - serial CRC-4 codeword checker with link statistics
module crc_checker #(
    parameter int                DATA_W = 8,
    parameter int                CRC_W  = 4,
    parameter logic [CRC_W-1:0]  POLY   = 4'h3,
    parameter int                CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W+CRC_W-1:0]   codeword_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         data_out,
    output logic [CRC_W-1:0]          syndrome,
    output logic                      crc_err,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      clr_stats,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int CW = DATA_W + CRC_W;
    localparam int BW = $clog2(CW);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t              state_q;
    logic [CW-1:0]       shreg_q;
    logic [DATA_W-1:0]   cw_data_q;
    logic [CRC_W-1:0]    rem_q;
    logic [CRC_W-1:0]    rem_d;
    logic [BW-1:0]       bitcnt_q;
    logic [DATA_W-1:0]   data_q;
    logic [CRC_W-1:0]    syn_q;
    logic                err_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    frame_q;
    logic [CNT_W-1:0]    errc_q;
    logic                last_bit;
    logic                done;
    logic [CRC_W:0]      t;

    // One division step: append the next codeword bit and reduce by G
    always_comb begin
        t     = {rem_q, shreg_q[CW-1]};
        rem_d = t[CRC_W] ? (t[CRC_W-1:0] ^ POLY) : t[CRC_W-1:0];
    end

    assign last_bit = (bitcnt_q == BW'(CW - 1));
    assign done     = (state_q == SHIFT) && last_bit;

    // Control FSM: accept, shift CW bits, then hold the result until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cw_data_q   <= '0;
            rem_q       <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            syn_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q    <= codeword_in;
                        cw_data_q  <= codeword_in[CW-1:CRC_W];
                        rem_q      <= '0;
                        bitcnt_q   <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q  <= shreg_q << 1;
                    rem_q    <= rem_d;
                    bitcnt_q <= bitcnt_q + BW'(1);
                    if (last_bit) begin
                        // Outputs are only refreshed here so they persist past the handshake
                        data_q      <= cw_data_q;
                        syn_q       <= rem_d;
                        err_q       <= |rem_d;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; a clear request beats a same-edge increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q <= '0;
            errc_q  <= '0;
        end else if (clr_stats) begin
            frame_q <= '0;
            errc_q  <= '0;
        end else if (done) begin
            if (frame_q != '1) frame_q <= frame_q + CNT_W'(1);
            if ((|rem_d) && (errc_q != '1)) errc_q <= errc_q + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    assign syndrome  = syn_q;
    assign crc_err   = err_q;
    assign frame_cnt = frame_q;
    assign err_cnt   = errc_q;

endmodule

// File: tb/tb_crc_checker.sv
// tb/tb_crc_checker.sv - self-checking bench for crc_checker
module tb_crc_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] codeword_in = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_stats = 1'b0;
    logic        in_ready, out_valid, crc_err;
    logic [7:0]  data_out;
    logic [3:0]  syndrome;
    logic [15:0] frame_cnt, err_cnt;
    logic        in_ready_s, out_valid_s, crc_err_s;
    logic [7:0]  data_out_s;
    logic [3:0]  syndrome_s;
    logic [3:0]  frame_cnt_s, err_cnt_s;

    int tests = 0;
    int fails = 0;
    int fc = 0, ec = 0, fcs = 0, ecs = 0;

    always #5 clk = ~clk;

    crc_checker dut (
        .clk(clk), .rst_n(rst_n), .codeword_in(codeword_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .syndrome(syndrome), .crc_err(crc_err),
        .out_valid(out_valid), .out_ready(out_ready), .clr_stats(clr_stats),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    crc_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .codeword_in(codeword_in), .in_valid(in_valid),
        .in_ready(in_ready_s), .data_out(data_out_s), .syndrome(syndrome_s), .crc_err(crc_err_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .clr_stats(clr_stats),
        .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s)
    );

    // Polynomial long division of the whole codeword by x^4+x+1
    function automatic logic [3:0] ref_mod(input logic [11:0] cw);
        logic [11:0] r;
        r = cw;
        for (int i = 11; i >= 4; i--)
            if (r[i]) r = r ^ (12'h013 << (i - 4));
        return r[3:0];
    endfunction

    function automatic logic [11:0] make_cw(input logic [7:0] d);
        logic [11:0] c;
        c = {d, 4'h0};
        return {d, ref_mod(c)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats();
        chk("frame_cnt", frame_cnt, fc[15:0]);
        chk("err_cnt", err_cnt, ec[15:0]);
        chk("frame_cnt_small", frame_cnt_s, fcs[3:0]);
        chk("err_cnt_small", err_cnt_s, ecs[3:0]);
    endtask

    task automatic do_frame(input logic [11:0] cw, input int stall, input bit clr_done);
        int lat, low;
        logic [3:0] syn;
        chk("idle_in_ready", in_ready, 1);
        out_ready = (stall == 0);
        @(negedge clk);
        codeword_in = cw;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        codeword_in = 12'($urandom);
        lat = 0;
        low = 0;
        while (!out_valid && lat < 40) begin
            if (!in_ready) low++;
            if (clr_done && lat == 11) clr_stats = 1'b1;
            @(posedge clk); #1;
            clr_stats = 1'b0;
            lat++;
        end
        if (!in_ready) low++;
        chk("latency", lat, 12);
        syn = ref_mod(cw);
        if (clr_done) begin
            fc = 0; ec = 0; fcs = 0; ecs = 0;
        end else begin
            fc  = (fc == 65535) ? fc : fc + 1;
            fcs = (fcs == 15) ? fcs : fcs + 1;
            if (syn != 4'h0) begin
                ec  = (ec == 65535) ? ec : ec + 1;
                ecs = (ecs == 15) ? ecs : ecs + 1;
            end
        end
        chk("data_out", data_out, cw[11:4]);
        chk("syndrome", syndrome, syn);
        chk("crc_err", crc_err, (syn != 4'h0));
        chk_stats();
        for (int k = 0; k < stall; k++) begin
            in_valid = 1'($urandom);
            codeword_in = 12'($urandom);
            @(posedge clk); #1;
            if (!in_ready) low++;
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_data", {crc_err, syndrome, data_out}, {(syn != 4'h0), syn, cw[11:4]});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_out_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hold_data", {crc_err, syndrome, data_out}, {(syn != 4'h0), syn, cw[11:4]});
        if (stall == 0) chk("in_ready_low_cycles", low, 13);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] cw;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", {crc_err, syndrome, data_out}, 0);
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;

        do_frame(12'hCCE, 0, 0);
        do_frame(12'hAA9, 0, 0);
        do_frame(12'hCCF, 0, 0);
        chk("cCF_syndrome", syndrome, 4'h1);
        do_frame(12'h4CE, 0, 0);
        chk("4CE_syndrome", syndrome, 4'hE);
        do_frame(make_cw(8'($urandom)), 20, 0);

        for (int i = 0; i < 10; i++) begin
            cw = ($urandom_range(0, 1) == 1) ? make_cw(8'($urandom)) : 12'($urandom);
            do_frame(cw, $urandom_range(0, 3), 0);
        end

        @(negedge clk);
        codeword_in = 12'h3C5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        fc = 0; ec = 0; fcs = 0; ecs = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {crc_err, syndrome, data_out}, 0);
        chk_stats();
        @(negedge clk);
        rst_n = 1'b1;
        do_frame(12'hCCE, 0, 0);

        for (int i = 0; i < 16; i++) do_frame(12'hCCF, 0, 0);
        chk("err_cnt_small_sat", err_cnt_s, 4'hF);
        do_frame(12'h4CE, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
